// File: rtl/yarvi_uart_rx.sv
// UART receiver: 2-flop synchroniser, 8N1 bit-timing FSM, FWFT FIFO with valid/ready output.
// Define YARVI_UART_RX_PARITY_EN to receive 8E1 frames and report parity_error.
module yarvi_uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_LOG2    = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rxd,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       frame_error,
    output logic       overrun,
    output logic       parity_error
);

    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    // ---------------- synchroniser ----------------
    logic rx_meta;
    logic rxs;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    // ---------------- bit-timing FSM ----------------
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tick;
    logic          byte_done;
    logic          fe_d;
    logic          pe_d;
    logic          parity_bad;

`ifdef YARVI_UART_RX_PARITY_EN
    logic par_q, par_d;
    assign parity_bad = ^{shift_q, par_q};
`else
    assign parity_bad = 1'b0;
`endif

    assign tick = (cnt_q == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
`ifdef YARVI_UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
`ifdef YARVI_UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = tick ? cnt_q : cnt_q - 1'b1;
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        fe_d      = 1'b0;
        pe_d      = 1'b0;
`ifdef YARVI_UART_RX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    cnt_d   = HALF_RELOAD;
                end
            end
            START: begin
                if (tick) begin
                    if (!rxs) begin
                        state_d = DATA;
                        cnt_d   = FULL_RELOAD;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d[idx_q] = rxs;
                    cnt_d          = FULL_RELOAD;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef YARVI_UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef YARVI_UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    par_d   = rxs;
                    cnt_d   = FULL_RELOAD;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    // A bad stop bit outranks a parity mismatch.
                    if (!rxs) begin
                        fe_d    = 1'b1;
                        state_d = WAIT_HIGH;
                    end else if (parity_bad) begin
                        pe_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        byte_done = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FIFO ----------------
    logic [FIFO_LOG2:0] wr_ptr, rd_ptr;
    logic [7:0]         mem [DEPTH];
    logic               empty;
    logic               full;
    logic               pop;
    logic               push;
    logic               ovr_d;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_LOG2] != rd_ptr[FIFO_LOG2]) &&
                   (wr_ptr[FIFO_LOG2-1:0] == rd_ptr[FIFO_LOG2-1:0]);
    assign pop   = out_valid && out_ready;
    // When full, a same-cycle pop frees the very slot the push overwrites.
    assign push  = byte_done && (!full || pop);
    assign ovr_d = byte_done && full && !pop;

    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr[FIFO_LOG2-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[FIFO_LOG2-1:0]] <= shift_q;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // ---------------- error pulses ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= fe_d;
            overrun     <= ovr_d;
        end
    end

`ifdef YARVI_UART_RX_PARITY_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            parity_error <= 1'b0;
        end else begin
            parity_error <= pe_d;
        end
    end
`else
    assign parity_error = 1'b0;
    logic unused_pe;
    assign unused_pe = pe_d;
`endif

endmodule
